link_mm_arbiter: RTL and testbench

LINK_MM_ARBITER -- requirements
Module: link_mm_arbiter

---
 rtl/link_mm_arb_pkg.sv | 19 +
 rtl/link_mm_arbiter_rr_arb2.sv | 19 +
 rtl/link_mm_arbiter.sv | 145 ++++++++++++++
 tb/tb_link_mm_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/link_mm_arb_pkg.sv
// Shared types and widths for the two-master memory-mapped link arbiter.
// Holds the FSM state encoding, bus widths and the saturating counter helper.
package link_mm_arb_pkg;

  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 64;
  localparam int TO_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  function automatic logic [TO_CNT_W-1:0] sat_inc(input logic [TO_CNT_W-1:0] v);
    return (&v) ? v : v + TO_CNT_W'(1);
  endfunction

endpackage

// File: rtl/link_mm_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// master that was not granted last. Grant is one-hot, zero when idle.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,   // 1: master 1 was granted last
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/link_mm_arbiter.sv
// Arbitrates host (M0) and local sequencer (M1) onto one decoder port,
// with a read-wait timeout that returns a marker word instead of data.
module link_mm_arbiter
  import link_mm_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [31:0] TO_PATTERN  = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iM0_WR_EN,
  input  logic              iM0_RD_EN,
  input  logic [ADDR_W-1:0] iM0_ADDR,
  input  logic [DATA_W-1:0] iM0_WR_DATA,
  output logic              oM0_ACK,
  output logic [DATA_W-1:0] oM0_RD_DATA,
  output logic              oM0_RD_DATA_V,
  input  logic              iM1_WR_EN,
  input  logic              iM1_RD_EN,
  input  logic [ADDR_W-1:0] iM1_ADDR,
  input  logic [DATA_W-1:0] iM1_WR_DATA,
  output logic              oM1_ACK,
  output logic [DATA_W-1:0] oM1_RD_DATA,
  output logic              oM1_RD_DATA_V,
  output logic              oMM_WR_EN,
  output logic              oMM_RD_EN,
  output logic [ADDR_W-1:0] oMM_ADDR,
  output logic [DATA_W-1:0] oMM_WR_DATA,
  input  logic [DATA_W-1:0] iMM_RD_DATA,
  input  logic              iMM_RD_DATA_V,
  output logic              oTIMEOUT,
  output logic [TO_CNT_W-1:0] oTO_CNT
);

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYC);

  state_e              state_q;
  logic                last_q;
  logic                sel_q;
  logic                wr_q;
  logic [TO_CNT_W-1:0] cnt_q;
  logic                mm_wr_q, mm_rd_q;
  logic [ADDR_W-1:0]   mm_addr_q;
  logic [DATA_W-1:0]   mm_wdata_q;
  logic [1:0]          ack_q, rdv_q;
  logic [DATA_W-1:0]   rdd_q [2];
  logic                to_q;
  logic [TO_CNT_W-1:0] to_cnt_q;

  logic [1:0]          req_d, gnt_d;
  logic                sel_wr_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_data_d;
  logic [DATA_W-1:0]   rd_ret_d;

  assign req_d = {iM1_WR_EN | iM1_RD_EN, iM0_WR_EN | iM0_RD_EN};

  rr_arb2 u_rr (
    .req_i  (req_d),
    .last_i (last_q),
    .gnt_o  (gnt_d)
  );

  // A request with both enables set is a write; RD_EN only matters alone.
  assign sel_wr_d   = gnt_d[1] ? iM1_WR_EN   : iM0_WR_EN;
  assign sel_addr_d = gnt_d[1] ? iM1_ADDR    : iM0_ADDR;
  assign sel_data_d = gnt_d[1] ? iM1_WR_DATA : iM0_WR_DATA;

  // Real data has priority, so a valid on the final wait cycle is never lost.
  assign rd_ret_d = iMM_RD_DATA_V ? iMM_RD_DATA
                                  : {TO_PATTERN, {(DATA_W-32-ADDR_W){1'b0}}, mm_addr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      mm_wr_q    <= 1'b0;
      mm_rd_q    <= 1'b0;
      mm_addr_q  <= '0;
      mm_wdata_q <= '0;
      ack_q      <= 2'b00;
      rdv_q      <= 2'b00;
      rdd_q[0]   <= '0;
      rdd_q[1]   <= '0;
      to_q       <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      mm_wr_q <= 1'b0;
      mm_rd_q <= 1'b0;
      ack_q   <= 2'b00;
      rdv_q   <= 2'b00;
      to_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_d) begin
            sel_q      <= gnt_d[1];
            last_q     <= gnt_d[1];
            wr_q       <= sel_wr_d;
            mm_addr_q  <= sel_addr_d;
            mm_wdata_q <= sel_data_d;
            mm_wr_q    <= sel_wr_d;
            mm_rd_q    <= ~sel_wr_d;
            ack_q      <= gnt_d;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= TO_CNT_W'(1);
          state_q <= wr_q ? IDLE : RD_WAIT;
        end
        RD_WAIT: begin
          if (iMM_RD_DATA_V || (cnt_q == TO_LIMIT)) begin
            rdd_q[sel_q] <= rd_ret_d;
            rdv_q[sel_q] <= 1'b1;
            state_q      <= IDLE;
            if (!iMM_RD_DATA_V) begin
              to_q     <= 1'b1;
              to_cnt_q <= sat_inc(to_cnt_q);
            end
          end else begin
            cnt_q <= cnt_q + TO_CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oMM_WR_EN     = mm_wr_q;
  assign oMM_RD_EN     = mm_rd_q;
  assign oMM_ADDR      = mm_addr_q;
  assign oMM_WR_DATA   = mm_wdata_q;
  assign oM0_ACK       = ack_q[0];
  assign oM1_ACK       = ack_q[1];
  assign oM0_RD_DATA_V = rdv_q[0];
  assign oM1_RD_DATA_V = rdv_q[1];
  assign oM0_RD_DATA   = rdd_q[0];
  assign oM1_RD_DATA   = rdd_q[1];
  assign oTIMEOUT      = to_q;
  assign oTO_CNT       = to_cnt_q;

endmodule

// File: tb/tb_link_mm_arbiter.sv
// Self-checking bench: directed table, reset/throughput sequences and
// randomized rounds checked against a transaction-level arbiter model.
module tb_link_mm_arbiter;

  localparam int          TO  = 64;
  localparam logic [31:0] TOP = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wr_i = 2'b00, rd_i = 2'b00;
  logic [16:0] addr_i [2];
  logic [63:0] wdat_i [2];
  logic [63:0] mm_rdata = '0;
  logic        mm_rdv = 1'b0;

  logic [1:0]  ack_o, rdv_o;
  logic [63:0] rdd0_o, rdd1_o;
  logic        mm_wr, mm_rd, to_o;
  logic [16:0] mm_addr;
  logic [63:0] mm_wdata;
  logic [15:0] to_cnt;

  int errors = 0;
  int checks = 0;

  int          last_m = 1;
  logic [15:0] to_cnt_m = '0;
  logic [63:0] rd_last_m [2];

  always #5 clk = ~clk;

  link_mm_arbiter #(.TIMEOUT_CYC(TO), .TO_PATTERN(TOP)) dut (
    .clk(clk), .rst(rst),
    .iM0_WR_EN(wr_i[0]), .iM0_RD_EN(rd_i[0]), .iM0_ADDR(addr_i[0]), .iM0_WR_DATA(wdat_i[0]),
    .oM0_ACK(ack_o[0]), .oM0_RD_DATA(rdd0_o), .oM0_RD_DATA_V(rdv_o[0]),
    .iM1_WR_EN(wr_i[1]), .iM1_RD_EN(rd_i[1]), .iM1_ADDR(addr_i[1]), .iM1_WR_DATA(wdat_i[1]),
    .oM1_ACK(ack_o[1]), .oM1_RD_DATA(rdd1_o), .oM1_RD_DATA_V(rdv_o[1]),
    .oMM_WR_EN(mm_wr), .oMM_RD_EN(mm_rd), .oMM_ADDR(mm_addr), .oMM_WR_DATA(mm_wdata),
    .iMM_RD_DATA(mm_rdata), .iMM_RD_DATA_V(mm_rdv),
    .oTIMEOUT(to_o), .oTO_CNT(to_cnt)
  );

  typedef struct {
    int          op0;  // 0 none, 1 write, 2 read, 3 both enables
    int          op1;
    logic [16:0] a0, a1;
    logic [63:0] d0, d1;
    int          delay;  // RD_WAIT cycle of decoder valid; 0 = silent
    logic [63:0] ddata;
    int          exp_w;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rdd(input int m);
    return (m == 0) ? rdd0_o : rdd1_o;
  endfunction

  function automatic logic [1:0] onehot(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic int model_winner();
    logic r0, r1;
    r0 = wr_i[0] | rd_i[0];
    r1 = wr_i[1] | rd_i[1];
    if (r0 && r1) return 1 - last_m;
    return r0 ? 0 : 1;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, " quiet"}, {59'd0, mm_wr, mm_rd, ack_o, rdv_o, to_o}, 64'd0);
  endtask

  task automatic set_req(input int m, input int op, input logic [16:0] a, input logic [63:0] d);
    wr_i[m]   = (op == 1) || (op == 3);
    rd_i[m]   = (op == 2) || (op == 3);
    addr_i[m] = a;
    wdat_i[m] = d;
  endtask

  // Called during an IDLE cycle with requests already driven; returns at the
  // negedge of the next IDLE cycle after the transaction completes.
  task automatic serve(input int w, input int delay, input logic [63:0] ddata, input string tag);
    logic        is_wr, to_exp;
    logic [16:0] a;
    logic [63:0] d, exp;
    int          o;
    o     = 1 - w;
    is_wr = wr_i[w];
    a     = addr_i[w];
    d     = wdat_i[w];
    @(posedge clk); @(negedge clk);
    chk({tag, " ack"}, {62'd0, ack_o}, {62'd0, onehot(w)});
    chk({tag, " mm_en"}, {62'd0, mm_wr, mm_rd}, is_wr ? 64'd2 : 64'd1);
    chk({tag, " mm_addr"}, {47'd0, mm_addr}, {47'd0, a});
    if (is_wr) chk({tag, " mm_wdata"}, mm_wdata, d);
    chk({tag, " issue rdv/to"}, {61'd0, rdv_o, to_o}, 64'd0);
    last_m = w;
    wr_i[w] = 1'b0;
    rd_i[w] = 1'b0;
    if (is_wr) begin
      @(posedge clk); @(negedge clk);
      check_quiet({tag, " post-wr"});
      return;
    end
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); @(negedge clk);
      check_quiet({tag, " wait"});
      mm_rdv   = (k == delay);
      mm_rdata = (k == delay) ? ddata : {$urandom, $urandom};
      if (k == delay) break;
    end
    @(posedge clk); @(negedge clk);
    mm_rdv = 1'b0;
    to_exp = !((delay >= 1) && (delay <= TO));
    exp    = to_exp ? {TOP, 15'd0, a} : ddata;
    if (to_exp && to_cnt_m != 16'hFFFF) to_cnt_m++;
    chk({tag, " rd_v"}, {62'd0, rdv_o}, {62'd0, onehot(w)});
    chk({tag, " rd_data"}, rdd(w), exp);
    chk({tag, " other rd_data held"}, rdd(o), rd_last_m[o]);
    chk({tag, " timeout"}, {63'd0, to_o}, {63'd0, to_exp});
    chk({tag, " to_cnt"}, {48'd0, to_cnt}, {48'd0, to_cnt_m});
    chk({tag, " ret en/ack"}, {60'd0, mm_wr, mm_rd, ack_o}, 64'd0);
    rd_last_m[w] = exp;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    vec_t vecs [10];
    int   w, sel, dly;

    addr_i[0] = '0; addr_i[1] = '0;
    wdat_i[0] = '0; wdat_i[1] = '0;
    rd_last_m[0] = '0; rd_last_m[1] = '0;

    vecs[0] = '{2, 2, 17'h00100, 17'h00200, 64'h0, 64'h0, 3, 64'hA, 0};
    vecs[1] = '{0, 2, 17'h00100, 17'h00200, 64'h0, 64'h0, 2, 64'hB, 1};
    vecs[2] = '{1, 0, 17'h00010, 17'h0,     64'h1234, 64'h0, 0, 64'h0, 0};
    vecs[3] = '{0, 2, 17'h0,     17'h04001, 64'h0, 64'h0, 0, 64'h0, 1};
    vecs[4] = '{2, 0, 17'h1FFFF, 17'h0,     64'h0, 64'h0, TO, 64'h5555_AAAA_0123_4567, 0};
    vecs[5] = '{1, 1, 17'h00003, 17'h00004, 64'h1, 64'h2, 0, 64'h0, 1};
    vecs[6] = '{1, 0, 17'h00003, 17'h0,     64'h1, 64'h0, 0, 64'h0, 0};
    vecs[7] = '{3, 0, 17'h00007, 17'h0,     64'h77, 64'h0, 0, 64'h0, 0};
    vecs[8] = '{2, 2, 17'h00021, 17'h00022, 64'h0, 64'h0, TO - 1, 64'hC, 1};
    vecs[9] = '{2, 0, 17'h00021, 17'h0,     64'h0, 64'h0, 1, 64'hD, 0};

    // Reset values
    @(negedge clk);
    chk("reset ctrl", {59'd0, mm_wr, mm_rd, ack_o, rdv_o, to_o}, 64'd0);
    chk("reset mm_addr", {47'd0, mm_addr}, 64'd0);
    chk("reset to_cnt", {48'd0, to_cnt}, 64'd0);
    chk("reset rd_data", rdd0_o | rdd1_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      set_req(0, vecs[i].op0, vecs[i].a0, vecs[i].d0);
      set_req(1, vecs[i].op1, vecs[i].a1, vecs[i].d1);
      serve(vecs[i].exp_w, vecs[i].delay, vecs[i].ddata, $sformatf("vec%0d", i));
    end
    set_req(0, 0, '0, '0);
    set_req(1, 0, '0, '0);

    // Decoder valid outside RD_WAIT must be ignored
    mm_rdv = 1'b1; mm_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk); @(negedge clk);
    check_quiet("stray valid");
    mm_rdv = 1'b0;

    // Both masters writing back-to-back: alternate grants, one write per 2 cycles
    set_req(0, 1, 17'h00100, 64'h100);
    set_req(1, 1, 17'h00200, 64'h200);
    for (int i = 0; i < 10; i++) begin
      w = 1 - last_m;
      serve(w, 0, '0, $sformatf("stream%0d", i));
      set_req(w, 1, addr_i[w] + 17'd1, wdat_i[w] + 64'd1);
    end
    set_req(0, 0, '0, '0);
    set_req(1, 0, '0, '0);

    // Reset in the middle of a read wait abandons it
    set_req(0, 2, 17'h00055, '0);
    @(posedge clk); @(negedge clk);
    chk("rstmid ack", {62'd0, ack_o}, 64'd1);
    set_req(0, 0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid ctrl", {59'd0, mm_wr, mm_rd, ack_o, rdv_o, to_o}, 64'd0);
    chk("rstmid mm_addr", {47'd0, mm_addr}, 64'd0);
    chk("rstmid to_cnt", {48'd0, to_cnt}, 64'd0);
    chk("rstmid rd_data", rdd0_o | rdd1_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_m = 1; to_cnt_m = '0; rd_last_m[0] = '0; rd_last_m[1] = '0;
    mm_rdv = 1'b1; mm_rdata = 64'h0BAD;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check_quiet("rstmid late valid");
    end
    mm_rdv = 1'b0;
    set_req(1, 2, 17'h00066, '0);
    serve(1, 2, 64'h6666, "post-rst read");

    // Randomized rounds against the model
    for (int r = 0; r < 40; r++) begin
      for (int m = 0; m < 2; m++) begin
        if (!(wr_i[m] | rd_i[m]) && ($urandom_range(0, 99) < 60))
          set_req(m, $urandom_range(1, 3), 17'($urandom), {$urandom, $urandom});
      end
      if (!(|(wr_i | rd_i))) begin
        mm_rdv = 1'b1; mm_rdata = {$urandom, $urandom};
        @(posedge clk); @(negedge clk);
        mm_rdv = 1'b0;
        check_quiet("rnd idle");
        continue;
      end
      w   = model_winner();
      sel = $urandom_range(0, 9);
      if (sel < 5)       dly = $urandom_range(1, 8);
      else if (sel < 7)  dly = TO;
      else if (sel == 7) dly = TO - 1;
      else               dly = 0;
      serve(w, dly, {$urandom, $urandom}, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
